// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm annunciator arbiter.
// Channel indices, the no-grant select code and the mod-3 helpers live here.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ANN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [1:0] SRC_H    = 2'd0;
  localparam logic [1:0] SRC_DC   = 2'd1;
  localparam logic [1:0] SRC_C    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Next channel in round-robin order; the unused code 3 folds back to H.
  function automatic logic [1:0] inc3(input logic [1:0] idx);
    case (idx)
      SRC_H:   inc3 = SRC_DC;
      SRC_DC:  inc3 = SRC_C;
      default: inc3 = SRC_H;
    endcase
  endfunction

  function automatic logic [2:0] idx2oh(input logic [1:0] idx);
    case (idx)
      SRC_H:   idx2oh = 3'b001;
      SRC_DC:  idx2oh = 3'b010;
      SRC_C:   idx2oh = 3'b100;
      default: idx2oh = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alarm_arbiter_rr_pick3.sv
// Combinational round-robin picker over three pending alarm channels.
// Search order is ptr, ptr+1, ptr+2 (mod 3); the first pending channel wins.
module rr_pick3
  import alarm_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx,
  output logic [2:0] onehot
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  // Rotate the search order and select the first pending candidate.
  always_comb begin
    c0     = (ptr == SEL_NONE) ? SRC_H : ptr;
    c1     = inc3(c0);
    c2     = inc3(c1);
    valid  = 1'b0;
    idx    = SEL_NONE;
    onehot = 3'b000;
    if ((pending & idx2oh(c0)) != 3'b000) begin
      valid  = 1'b1;
      idx    = c0;
      onehot = idx2oh(c0);
    end else if ((pending & idx2oh(c1)) != 3'b000) begin
      valid  = 1'b1;
      idx    = c1;
      onehot = idx2oh(c1);
    end else if ((pending & idx2oh(c2)) != 3'b000) begin
      valid  = 1'b1;
      idx    = c2;
      onehot = idx2oh(c2);
    end else begin
      valid  = 1'b0;
    end
  end

endmodule

// File: rtl/alarm_arbiter.sv
// Shares one buzzer and source-select code among the H, DC and C alarms.
// Alarm onsets are latched and announced one at a time in round-robin order.
module alarm_arbiter
  import alarm_pkg::*;
#(
  parameter int MIN_TICKS = 4,
  parameter int MAX_TICKS = 16,
  parameter int GAP_TICKS = 2,
  parameter int CNT_W     = 5
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] req,
  input  logic       ack,
  output logic [2:0] grant,
  output logic [1:0] sel,
  output logic       buzz,
  output logic [2:0] pending
);

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_TICKS);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       req_prev_q, req_prev_d;
  logic             ack_prev_q, ack_prev_d;
  logic [2:0]       pending_q, pending_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             buzz_q, buzz_d;

  logic [2:0]       req_rise;
  logic             ack_rise;
  logic [CNT_W-1:0] cnt_inc;
  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [2:0]       pick_oh;

  rr_pick3 u_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx),
    .onehot  (pick_oh)
  );

  assign req_rise = req & ~req_prev_q;
  assign ack_rise = ack & ~ack_prev_q;
  assign cnt_inc  = (cnt_q >= MAX_C) ? MAX_C : cnt_q + ONE_C;

  // Next-state logic; a fresh rising edge always re-sets its pending bit, even over an ack clear.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    req_prev_d = req;
    ack_prev_d = ack;
    pending_d  = pending_q | req_rise;
    grant_d    = grant_q;
    sel_d      = sel_q;
    buzz_d     = buzz_q;
    case (state_q)
      IDLE: begin
        grant_d = 3'b000;
        sel_d   = SEL_NONE;
        buzz_d  = 1'b0;
        if (pick_valid) begin
          grant_d = pick_oh;
          sel_d   = pick_idx;
          cnt_d   = ZERO_C;
          state_d = ANN;
        end else begin
          state_d = IDLE;
        end
      end
      ANN: begin
        if (ack_rise && (cnt_q >= MIN_C)) begin
          pending_d = (pending_q & ~grant_q) | req_rise;
          ptr_d     = inc3(sel_q);
          cnt_d     = ZERO_C;
          grant_d   = 3'b000;
          sel_d     = SEL_NONE;
          buzz_d    = 1'b0;
          state_d   = GAP;
        end else if (tick) begin
          if (cnt_inc == MAX_C) begin
            ptr_d   = inc3(sel_q);
            cnt_d   = ZERO_C;
            grant_d = 3'b000;
            sel_d   = SEL_NONE;
            buzz_d  = 1'b0;
            state_d = GAP;
          end else begin
            cnt_d  = cnt_inc;
            buzz_d = ~buzz_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      GAP: begin
        grant_d = 3'b000;
        sel_d   = SEL_NONE;
        buzz_d  = 1'b0;
        if (tick) begin
          if (cnt_inc >= GAP_C) begin
            cnt_d   = ZERO_C;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO_C;
        grant_d = 3'b000;
        sel_d   = SEL_NONE;
        buzz_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= SRC_H;
      cnt_q      <= ZERO_C;
      req_prev_q <= 3'b000;
      ack_prev_q <= 1'b0;
      pending_q  <= 3'b000;
      grant_q    <= 3'b000;
      sel_q      <= SEL_NONE;
      buzz_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      req_prev_q <= req_prev_d;
      ack_prev_q <= ack_prev_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      buzz_q     <= buzz_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign buzz    = buzz_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_alarm_arbiter.sv
// Self-checking bench for alarm_arbiter: per-feature tasks with inline checks,
// plus a grant-order scoreboard filled by the tasks and drained against a monitor.
module tb_alarm_arbiter;

  logic       CLK = 1'b0;
  logic       reset;
  logic       tick;
  logic [2:0] req;
  logic       ack;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       buzz;
  logic [2:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];
  logic [2:0] grant_prev = 3'b000;

  always #5 CLK = ~CLK;

  alarm_arbiter #(
    .MIN_TICKS(4), .MAX_TICKS(16), .GAP_TICKS(2), .CNT_W(5)
  ) dut (
    .CLK(CLK), .reset(reset), .tick(tick), .req(req), .ack(ack),
    .grant(grant), .sel(sel), .buzz(buzz), .pending(pending)
  );

  // Record every new grant onset for the scoreboard.
  always @(negedge CLK) begin
    if (grant !== 3'b000 && grant_prev === 3'b000) got_q.push_back(grant);
    grant_prev <= grant;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input logic t);
    tick = t;
    @(posedge CLK);
    #1;
    tick = 1'b0;
  endtask

  task automatic ann_ack(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
    ack = 1'b1;
    cyc(1'b0);
    ack = 1'b0;
  endtask

  task automatic gap();
    cyc(1'b1);
    cyc(1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 3'b000; ack = 1'b0; tick = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (grant !== 3'b000) $display("FAIL reset_grant: got %b exp 000", grant); else n_pass++;
    n_checks++; if (sel !== 2'd3) $display("FAIL reset_sel: got %0d exp 3", sel); else n_pass++;
    n_checks++; if (buzz !== 1'b0) $display("FAIL reset_buzz: got %b exp 0", buzz); else n_pass++;
    n_checks++; if (pending !== 3'b000) $display("FAIL reset_pending: got %b exp 000", pending); else n_pass++;
    reset = 1'b1;
    cyc(1'b0);
  endtask

  task automatic test_single();
    logic eb;
    req = 3'b010;
    cyc(1'b0);
    n_checks++; if (pending !== 3'b010) $display("FAIL single_pending: got %b exp 010", pending); else n_pass++;
    n_checks++; if (grant !== 3'b000) $display("FAIL single_grant_early: got %b exp 000", grant); else n_pass++;
    req = 3'b000;
    cyc(1'b0);
    n_checks++; if (grant !== 3'b010) $display("FAIL single_grant: got %b exp 010", grant); else n_pass++;
    n_checks++; if (sel !== 2'd1) $display("FAIL single_sel: got %0d exp 1", sel); else n_pass++;
    exp_q.push_back(3'b010);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      eb = (i % 2 == 0);
      n_checks++; if (buzz !== eb) $display("FAIL single_buzz%0d: got %b exp %b", i, buzz, eb); else n_pass++;
    end
    ack = 1'b1;
    cyc(1'b0);
    ack = 1'b0;
    n_checks++; if (grant !== 3'b000) $display("FAIL single_ack_grant: got %b exp 000", grant); else n_pass++;
    n_checks++; if (pending !== 3'b000) $display("FAIL single_ack_pending: got %b exp 000", pending); else n_pass++;
    n_checks++; if (sel !== 2'd3) $display("FAIL single_ack_sel: got %0d exp 3", sel); else n_pass++;
    n_checks++; if (buzz !== 1'b0) $display("FAIL single_ack_buzz: got %b exp 0", buzz); else n_pass++;
    gap();
  endtask

  task automatic test_early_ack();
    req = 3'b001;
    cyc(1'b0);
    req = 3'b000;
    cyc(1'b0);
    n_checks++; if (grant !== 3'b001) $display("FAIL early_grant: got %b exp 001", grant); else n_pass++;
    exp_q.push_back(3'b001);
    cyc(1'b1);
    cyc(1'b1);
    ack = 1'b1;
    cyc(1'b0);
    ack = 1'b0;
    n_checks++; if (grant !== 3'b001) $display("FAIL early_ignored: got %b exp 001", grant); else n_pass++;
    n_checks++; if (pending !== 3'b001) $display("FAIL early_pending: got %b exp 001", pending); else n_pass++;
    ann_ack(3);
    n_checks++; if (grant !== 3'b000) $display("FAIL early_second_ack: got %b exp 000", grant); else n_pass++;
    n_checks++; if (pending !== 3'b000) $display("FAIL early_cleared: got %b exp 000", pending); else n_pass++;
    gap();
  endtask

  task automatic test_round_robin();
    logic [2:0] oh;
    logic [2:0] rem;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    req = 3'b111;
    cyc(1'b0);
    n_checks++; if (pending !== 3'b111) $display("FAIL rr_pending: got %b exp 111", pending); else n_pass++;
    req = 3'b000;
    cyc(1'b0);
    for (int k = 0; k < 3; k++) begin
      oh  = 3'(3'b001 << k);
      rem = 3'(3'b111 << (k + 1));
      n_checks++; if (grant !== oh) $display("FAIL rr_grant%0d: got %b exp %b", k, grant, oh); else n_pass++;
      n_checks++; if (sel !== 2'(k)) $display("FAIL rr_sel%0d: got %0d exp %0d", k, sel, k); else n_pass++;
      exp_q.push_back(oh);
      ann_ack(4);
      n_checks++; if (pending !== rem) $display("FAIL rr_rem%0d: got %b exp %b", k, pending, rem); else n_pass++;
      cyc(1'b1);
      n_checks++; if (grant !== 3'b000) $display("FAIL rr_gap1_%0d: got %b exp 000", k, grant); else n_pass++;
      cyc(1'b1);
      n_checks++; if (grant !== 3'b000) $display("FAIL rr_gap2_%0d: got %b exp 000", k, grant); else n_pass++;
      cyc(1'b0);
    end
  endtask

  task automatic test_timeout();
    req = 3'b101;
    cyc(1'b0);
    req = 3'b000;
    cyc(1'b0);
    n_checks++; if (grant !== 3'b001) $display("FAIL to_grant: got %b exp 001", grant); else n_pass++;
    exp_q.push_back(3'b001);
    repeat (15) cyc(1'b1);
    n_checks++; if (grant !== 3'b001) $display("FAIL to_before: got %b exp 001", grant); else n_pass++;
    cyc(1'b1);
    n_checks++; if (grant !== 3'b000) $display("FAIL to_drop: got %b exp 000", grant); else n_pass++;
    n_checks++; if (pending !== 3'b101) $display("FAIL to_pending: got %b exp 101", pending); else n_pass++;
    n_checks++; if (buzz !== 1'b0) $display("FAIL to_buzz: got %b exp 0", buzz); else n_pass++;
    gap();
    cyc(1'b0);
    n_checks++; if (grant !== 3'b100) $display("FAIL to_next_c: got %b exp 100", grant); else n_pass++;
    n_checks++; if (sel !== 2'd2) $display("FAIL to_next_sel: got %0d exp 2", sel); else n_pass++;
    exp_q.push_back(3'b100);
    ann_ack(4);
    n_checks++; if (pending !== 3'b001) $display("FAIL to_after_c: got %b exp 001", pending); else n_pass++;
    gap();
    cyc(1'b0);
    n_checks++; if (grant !== 3'b001) $display("FAIL to_h_again: got %b exp 001", grant); else n_pass++;
    exp_q.push_back(3'b001);
    ann_ack(4);
    n_checks++; if (pending !== 3'b000) $display("FAIL to_clear: got %b exp 000", pending); else n_pass++;
    gap();
  endtask

  task automatic test_edge_cases();
    req = 3'b010;
    cyc(1'b0);
    req = 3'b000;
    cyc(1'b0);
    n_checks++; if (grant !== 3'b010) $display("FAIL edge_grant: got %b exp 010", grant); else n_pass++;
    exp_q.push_back(3'b010);
    repeat (4) cyc(1'b1);
    ack = 1'b1;
    req = 3'b010;
    cyc(1'b0);
    req = 3'b000;
    n_checks++; if (grant !== 3'b000) $display("FAIL edge_ack_grant: got %b exp 000", grant); else n_pass++;
    n_checks++; if (pending !== 3'b010) $display("FAIL edge_set_wins: got %b exp 010", pending); else n_pass++;
    gap();
    cyc(1'b0);
    n_checks++; if (grant !== 3'b010) $display("FAIL edge_regrant: got %b exp 010", grant); else n_pass++;
    exp_q.push_back(3'b010);
    repeat (5) cyc(1'b1);
    cyc(1'b0);
    n_checks++; if (grant !== 3'b010) $display("FAIL edge_held_ack: got %b exp 010", grant); else n_pass++;
    n_checks++; if (pending !== 3'b010) $display("FAIL edge_held_pending: got %b exp 010", pending); else n_pass++;
    ack = 1'b0;
    cyc(1'b0);
    ack = 1'b1;
    cyc(1'b0);
    ack = 1'b0;
    n_checks++; if (grant !== 3'b000) $display("FAIL edge_fresh_ack: got %b exp 000", grant); else n_pass++;
    n_checks++; if (pending !== 3'b000) $display("FAIL edge_fresh_pending: got %b exp 000", pending); else n_pass++;
    gap();
  endtask

  task automatic test_reset_mid_ann();
    req = 3'b100;
    cyc(1'b0);
    req = 3'b000;
    cyc(1'b0);
    n_checks++; if (grant !== 3'b100) $display("FAIL rst_grant: got %b exp 100", grant); else n_pass++;
    exp_q.push_back(3'b100);
    cyc(1'b1);
    n_checks++; if (buzz !== 1'b1) $display("FAIL rst_buzz_on: got %b exp 1", buzz); else n_pass++;
    req = 3'b001;
    cyc(1'b0);
    req = 3'b000;
    n_checks++; if (pending !== 3'b101) $display("FAIL rst_pre_pending: got %b exp 101", pending); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (grant !== 3'b000) $display("FAIL rst_async_grant: got %b exp 000", grant); else n_pass++;
    n_checks++; if (sel !== 2'd3) $display("FAIL rst_async_sel: got %0d exp 3", sel); else n_pass++;
    n_checks++; if (buzz !== 1'b0) $display("FAIL rst_async_buzz: got %b exp 0", buzz); else n_pass++;
    n_checks++; if (pending !== 3'b000) $display("FAIL rst_async_pending: got %b exp 000", pending); else n_pass++;
    #2;
    reset = 1'b1;
    repeat (3) cyc(1'b1);
    n_checks++; if (grant !== 3'b000) $display("FAIL rst_no_grant: got %b exp 000", grant); else n_pass++;
    n_checks++; if (pending !== 3'b000) $display("FAIL rst_no_pending: got %b exp 000", pending); else n_pass++;
  endtask

  task automatic test_scoreboard();
    logic [2:0] e;
    logic [2:0] g;
    int idx;
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL sb_count: got %0d grants exp %0d", got_q.size(), exp_q.size());
    else n_pass++;
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 3'bxxx;
      n_checks++;
      if (g !== e) $display("FAIL sb_order%0d: got %b exp %b", idx, g, e); else n_pass++;
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_early_ack();
    test_round_robin();
    test_timeout();
    test_edge_cases();
    test_reset_mid_ann();
    test_scoreboard();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_arbiter.md
# alarm_arbiter

Shares the board's single audible annunciator (buzzer) and the source-select display code among the three alarm channels: smoke H, DC and C. It sits between the Moore alarm detector's three alarm outputs and the buzzer/display drivers. Each alarm onset is latched as a pending event and announced one at a time, in round-robin order. Announcement length is bounded by a minimum hold, operator acknowledge and a timeout.

## Interface
Parameters:
- MIN_TICKS, 4: ticks an announcement must last before an acknowledge is accepted.
- MAX_TICKS, 16: ticks without acknowledge before the arbiter times out and rotates.
- GAP_TICKS, 2: silent ticks between consecutive announcements.
- CNT_W, 5: tick counter width. Must hold MAX_TICKS.

Ports:
- CLK, in, 1: single system clock. All state is on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- tick, in, 1: one-CLK-wide timebase strobe from the clock divider.
- req, in, 3: alarm levels. [0]=H, [1]=DC, [2]=C. Synchronous to CLK.
- ack, in, 1: operator acknowledge level. Synchronous to CLK.
- grant, out, 3: one-hot, the channel currently being announced. 0 when none.
- sel, out, 2: binary index of the granted channel. 2'd3 when none.
- buzz, out, 1: annunciator drive. Toggles on every tick while announcing.
- pending, out, 3: latched, unacknowledged alarm events.

## Operation
- Event capture:
  - req_d is a registered copy of req.
  - A rising edge (req & ~req_d) sets the matching pending bit.
  - A bit clears only when its announcement is acknowledged.
  - A level held high does not re-arm. Only a new rising edge does.
- Acknowledge: ack_rise = ack & ~ack_d. Level-held ack has no further effect.
- Round-robin pointer ptr, 2 bits, range 0..2, reset 0:
  - The search runs ptr, ptr+1, ptr+2 (mod 3). The first pending bit found wins.
  - After a grant to channel i ends, by acknowledge or by timeout, ptr becomes (i+1) mod 3.
- States:
  - IDLE: grant=0, buzz=0. If pending≠0, latch the winner into grant, clear cnt, go to ANN.
  - ANN: grant and sel held. cnt increments on each tick. buzz toggles on each tick.
    - ack_rise with cnt≥MIN_TICKS: clear pending[granted], advance ptr, clear cnt, go to GAP.
    - ack_rise with cnt<MIN_TICKS: ignored and not remembered.
    - tick that brings cnt to MAX_TICKS with no accepted ack: pending stays set, advance ptr, clear cnt, go to GAP.
  - GAP: grant=0, buzz=0. cnt increments on tick. When cnt reaches GAP_TICKS, go to IDLE.
- Simultaneous events:
  - Accepted ack and timeout in the same cycle: the ack wins.
  - A new rising edge on the granted channel in the same cycle as its acknowledge: the set wins, so the bit stays pending.
  - No preemption. An alarm that arrives during ANN or GAP waits for the next arbitration.
- Counter: cnt saturates at MAX_TICKS and never wraps.

## Timing
- Reset values: grant=0, sel=2'd3, buzz=0, pending=0, state IDLE, ptr=0, cnt=0, req_d=0, ack_d=0.
- Reset is asynchronous. Asserting it mid-ANN drops all pending events immediately.
- Event latency: req rises before edge k, so pending is set after edge k. In IDLE, grant is valid after edge k+1.
- Acknowledge latency: grant drops one CLK after the accepted ack_rise edge.
- The next grant can appear no earlier than GAP_TICKS ticks plus 1 CLK after the GAP state is entered.
- buzz toggles on the same edge that samples tick=1.
- All outputs are registered.

## Structure
- Shared package alarm_pkg:
  - state enum (IDLE, ANN, GAP)
  - channel index constants SRC_H=0, SRC_DC=1, SRC_C=2
  - SEL_NONE=2'd3
- Sub-module rr_pick3: combinational round-robin picker.
  - Inputs: pending[2:0], ptr[1:0].
  - Outputs: valid, idx[1:0], onehot[2:0].
- The counter and the FSM stay in alarm_arbiter.

## Test plan
- Single event: pulse req=3'b010 high. Expect pending=010 after 1 CLK and grant=010, sel=1 after 2 CLK. buzz toggles each tick. ack rise at cnt=4 gives grant=0 next CLK, pending=0, ptr=2.
- Early acknowledge: ack rise at cnt=2 is ignored and grant stays set. A second ack rise at cnt=5 is accepted.
- Round-robin: raise req=3'b111 together. Grants go H, DC, C in order, each acked at cnt=4, with GAP_TICKS=2 silent ticks between grants.
- Timeout: req[0] rises and is never acked. After 16 ticks, grant drops and pending[0] stays 1. With req[2] also pending, the next grant is C (ptr=1 skips empty DC), then H again.
- Edge cases:
  - req[1] re-rises in the same cycle its ack is accepted: pending[1] stays 1.
  - ack held high does not clear the next grant.
- Reset mid-ANN: drive reset low during an announcement. All outputs go to reset values immediately. After release, no grant appears until a new req edge.
